// File: rtl/nn_sched_pkg.sv
// rtl/nn_sched_pkg.sv - shared widths, record types and helpers for the shared-multiplier scheduler
package nn_sched_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_A_W     = 4;
  localparam int DEF_B_W     = 5;
  localparam int DEF_P_W     = 9;

  // Smallest r with 2**r >= value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  localparam int DEF_ID_W = clog2(DEF_NUM_REQ);

  // Operand-stage record at the default configuration.
  typedef struct packed {
    logic                valid;
    logic [DEF_ID_W-1:0] id;
    logic [DEF_A_W-1:0]  a;
    logic [DEF_B_W-1:0]  b;
  } stage_rec_t;

  // Product-stage record at the default configuration.
  typedef struct packed {
    logic                valid;
    logic [DEF_ID_W-1:0] id;
    logic [DEF_P_W-1:0]  p;
  } result_rec_t;

endpackage

// File: rtl/nn_rr_arbiter.sv
// rtl/nn_rr_arbiter.sv - round-robin arbiter owning the rotating priority pointer
module nn_rr_arbiter
  import nn_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = clog2(NUM_REQ)
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_cand;

  // Search from the pointer upward with wrap; NUM_REQ is a power of two so
  // the ID_W-bit add wraps naturally. No grant at all while the stage stalls.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    w_cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = r_ptr + ID_W'(k);
      if (en && !grant_any && req_valid[w_cand]) begin
        grant_any      = 1'b1;
        grant_idx      = w_cand;
        grant[w_cand]  = 1'b1;
      end
    end
  end

  // Pointer moves just past the winner; idle or stalled cycles leave it alone.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_ptr <= '0;
    end else if (grant_any) begin
      r_ptr <= grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/nn_mul_share_sched.sv
// rtl/nn_mul_share_sched.sv - one unsigned multiplier shared round-robin among NUM_REQ requesters
module nn_mul_share_sched
  import nn_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = clog2(NUM_REQ),
  parameter int A_W     = DEF_A_W,
  parameter int B_W     = DEF_B_W,
  parameter int P_W     = DEF_P_W
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ID_W-1:0]        out_id,
  output logic [P_W-1:0]         out_data,
  output logic                   busy
);

  localparam int FULL_W = A_W + B_W;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic [A_W-1:0]  a;
    logic [B_W-1:0]  b;
  } s1_rec_t;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic [P_W-1:0]  p;
  } s2_rec_t;

  s1_rec_t r_s1;
  s2_rec_t r_s2;

  logic               w_s2_adv;
  logic               w_s1_adv;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_idx;
  logic               w_grant_any;
  logic [A_W-1:0]     w_a_arr [NUM_REQ];
  logic [B_W-1:0]     w_b_arr [NUM_REQ];
  logic [FULL_W-1:0]  w_prod_full;
  logic [P_W-1:0]     w_prod;

  // Stall chain: a stage may load when it is empty or its successor moves.
  assign w_s2_adv = !r_s2.valid || out_ready;
  assign w_s1_adv = !r_s1.valid || w_s2_adv;

  nn_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .en        (w_s1_adv),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .grant_any (w_grant_any)
  );

  assign req_ready = w_grant;

  // Unpack the flat operand buses so the winner can be selected by index.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_a_arr[gi] = req_a[gi*A_W +: A_W];
    assign w_b_arr[gi] = req_b[gi*B_W +: B_W];
  end

  // Full-width product, then resized to P_W (low bits kept when narrower).
  assign w_prod_full = FULL_W'(r_s1.a) * FULL_W'(r_s1.b);
  assign w_prod      = P_W'(w_prod_full);

  // Stage 1 captures the granted operands and requester id.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_s1 <= '0;
    end else if (w_s1_adv) begin
      r_s1.valid <= w_grant_any;
      r_s1.id    <= w_grant_idx;
      r_s1.a     <= w_a_arr[w_grant_idx];
      r_s1.b     <= w_b_arr[w_grant_idx];
    end
  end

  // Stage 2 holds the product; it only reloads when the consumer can move.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_s2 <= '0;
    end else if (w_s2_adv) begin
      r_s2.valid <= r_s1.valid;
      r_s2.id    <= r_s1.id;
      r_s2.p     <= w_prod;
    end
  end

  assign out_valid = r_s2.valid;
  assign out_id    = r_s2.id;
  assign out_data  = r_s2.p;
  assign busy      = r_s1.valid || r_s2.valid;

endmodule

// File: tb/tb_nn_mul_share_sched.sv
// tb/tb_nn_mul_share_sched.sv - directed bench for the shared-multiplier scheduler
module tb_nn_mul_share_sched;

  logic        ap_clk;
  logic        ap_rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_a;
  logic [19:0] req_b;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_id;
  logic [8:0]  out_data;
  logic        busy;

  logic [3:0]  req_ready8;
  logic        out_valid8;
  logic [1:0]  out_id8;
  logic [7:0]  out_data8;
  logic        busy8;

  int n_total;
  int n_bad;
  int prods [4];

  nn_mul_share_sched #(
    .NUM_REQ(4), .ID_W(2), .A_W(4), .B_W(5), .P_W(9)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_id    (out_id),
    .out_data  (out_data),
    .busy      (busy)
  );

  nn_mul_share_sched #(
    .NUM_REQ(4), .ID_W(2), .A_W(4), .B_W(5), .P_W(8)
  ) dut8 (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_ready (req_ready8),
    .req_a     (req_a),
    .req_b     (req_b),
    .out_valid (out_valid8),
    .out_ready (out_ready),
    .out_id    (out_id8),
    .out_data  (out_data8),
    .busy      (busy8)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive req_valid, check at the falling edge, advance past the rising edge.
  task automatic step(input string tag, input logic [3:0] rv, input logic [3:0] exp_rdy,
                      input logic exp_ov, input int exp_id, input int exp_p);
    req_valid = rv;
    @(negedge ap_clk);
    check({tag, "_rdy"}, 32'(req_ready), 32'(exp_rdy));
    check({tag, "_ov"}, 32'(out_valid), 32'(exp_ov));
    if (exp_ov) begin
      check({tag, "_id"}, 32'(out_id), exp_id);
      check({tag, "_p"}, 32'(out_data), exp_p);
      check({tag, "_p8"}, 32'(out_data8), exp_p & 255);
    end
    @(posedge ap_clk);
    #1;
  endtask

  initial begin
    logic [3:0] rdy;
    int         id;
    n_total   = 0;
    n_bad     = 0;
    prods     = '{15, 77, 465, 180};
    ap_rst    = 1'b1;
    out_ready = 1'b0;
    req_valid = 4'b0000;
    // requester 3..0: a = 9,15,7,3 ; b = 20,31,11,5
    req_a     = {4'd9, 4'd15, 4'd7, 4'd3};
    req_b     = {5'd20, 5'd31, 5'd11, 5'd5};

    // Reset state
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    check("rst_ov", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_id", 32'(out_id), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_rdy", 32'(req_ready), 0);
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;

    // Single requester 2 (15*31), two-cycle latency, truncation on dut8
    out_ready = 1'b1;
    step("s0", 4'b0100, 4'b0100, 1'b0, 0, 0);
    step("s1", 4'b0000, 4'b0000, 1'b0, 0, 0);
    step("s2", 4'b0000, 4'b0000, 1'b1, 2, 465);
    step("s3", 4'b0000, 4'b0000, 1'b0, 0, 0);

    // Wrap and skip: pointer at 3, only 0 and 1 requesting
    step("w0", 4'b0011, 4'b0001, 1'b0, 0, 0);
    step("w1", 4'b0011, 4'b0010, 1'b0, 0, 0);
    step("w2", 4'b0011, 4'b0001, 1'b1, 0, 15);
    step("w3", 4'b0000, 4'b0000, 1'b1, 1, 77);
    step("w4", 4'b0000, 4'b0000, 1'b1, 0, 15);
    step("w5", 4'b0000, 4'b0000, 1'b0, 0, 0);

    // Backpressure: pointer at 1, requests from 1,2,3, downstream stalled
    out_ready = 1'b0;
    step("b0", 4'b1110, 4'b0010, 1'b0, 0, 0);
    step("b1", 4'b1100, 4'b0100, 1'b0, 0, 0);
    check("b_busy1", 32'(busy), 1);
    for (int i = 0; i < 5; i++) begin
      step($sformatf("bh%0d", i), 4'b1000, 4'b0000, 1'b1, 1, 77);
    end
    out_ready = 1'b1;
    step("b7", 4'b1000, 4'b1000, 1'b1, 1, 77);
    step("b8", 4'b0000, 4'b0000, 1'b1, 2, 465);
    step("b9", 4'b0000, 4'b0000, 1'b1, 3, 180);
    step("b10", 4'b0000, 4'b0000, 1'b0, 0, 0);
    check("b_busy0", 32'(busy), 0);

    // Reset flush: load both stages, then reset
    out_ready = 1'b0;
    step("f0", 4'b1111, 4'b0001, 1'b0, 0, 0);
    step("f1", 4'b1111, 4'b0010, 1'b0, 0, 0);
    check("f_busy1", 32'(busy), 1);
    check("f_ov1", 32'(out_valid), 1);
    ap_rst    = 1'b1;
    req_valid = 4'b0000;
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    check("f_ov0", 32'(out_valid), 0);
    check("f_busy0", 32'(busy), 0);
    check("f_id0", 32'(out_id), 0);
    check("f_data0", 32'(out_data), 0);
    out_ready = 1'b1;
    step("f2", 4'b0000, 4'b0000, 1'b0, 0, 0);
    step("f3", 4'b0000, 4'b0000, 1'b0, 0, 0);

    // Full contention from pointer 0: grants 0,1,2,3,0 and results two cycles later
    for (int k = 0; k < 7; k++) begin
      rdy = (k < 5) ? (4'b0001 << (k % 4)) : 4'b0000;
      id  = (k >= 2) ? ((k - 2) % 4) : 0;
      step($sformatf("c%0d", k), (k < 5) ? 4'b1111 : 4'b0000, rdy,
           (k >= 2), id, prods[id]);
    end
    step("c7", 4'b0000, 4'b0000, 1'b0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/nn_mul_share_sched.md
Name: nn_mul_share_sched

Overview:
- Round-robin scheduler sharing one unsigned multiplier (A_W x B_W -> P_W) among NUM_REQ requesters in the NN conv datapath.
- Each requester presents operands with valid/ready. The block grants one per cycle and carries the requester ID through a two-stage pipeline (operand register, product register).
- It returns {id, product} on a single shared result channel with backpressure.
- Replaces per-PE multiplier instances where DSP/LUT budget is tight.

Parameters:
- NUM_REQ, 4, number of requesters (power of two, 2..8)
- ID_W, 2, width of requester ID (log2 NUM_REQ)
- A_W, 4, operand A width, unsigned
- B_W, 5, operand B width, unsigned
- P_W, 9, product width. Full product is A_W+B_W bits; if P_W is smaller, the low P_W bits are kept.

Ports:
- ap_clk  in  1  clock, all logic on rising edge
- ap_rst  in  1  synchronous reset, active-high
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_a  in  NUM_REQ*A_W  packed operand A, requester i at bits [i*A_W +: A_W]
- req_b  in  NUM_REQ*B_W  packed operand B, same packing
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_id  out  ID_W  requester index of result
- out_data  out  P_W  product
- busy  out  1  any pipeline stage holds data

Behaviour:
- Reset (ap_rst=1 at clock edge):
  - s1_valid=0, s2_valid=0, rr_ptr=0; out_valid=0, out_id=0, out_data=0, busy=0.
  - In-flight data is discarded; no partial results emerge after reset.
- Handshakes:
  - A transfer occurs on a cycle with valid&ready, on either channel.
  - req_ready may depend combinationally on req_valid.
  - Once asserted, out_valid/out_id/out_data are stable until out_ready=1.
- Stall chain:
  - s2_adv = !s2_valid | out_ready
  - s1_adv = !s1_valid | s2_adv
- Arbitration (combinational, only when s1_adv=1):
  - Search req_valid starting at index rr_ptr, ascending with wrap from NUM_REQ-1 to 0.
  - The first set index g gets req_ready[g]=1; all other ready bits are 0.
  - If s1_adv=0 or no request is pending, req_ready is all-zero.
- Pointer:
  - On a grant, rr_ptr <= (g+1) mod NUM_REQ.
  - With no grant, rr_ptr holds; it does not advance over idle cycles.
- Stage 1 (operand register):
  - Under s1_adv, s1 <= {grant_any, g, a_g, b_g}.
  - With s1_adv=0, s1 holds.
- Stage 2 (product register):
  - Under s2_adv, s2 <= {s1_valid, s1_id, s1_a*s1_b}.
  - Unsigned multiply, zero-extended to A_W+B_W bits, then truncated to P_W.
  - With s2_adv=0, s2 holds.
- Outputs:
  - out_valid=s2_valid, out_id=s2_id, out_data=s2_p.
  - Data fields are don't-care when not valid, but are reset to 0.
- Latency and throughput:
  - A grant in cycle N gives out_valid in cycle N+2 when unstalled.
  - Sustained throughput is 1 result/cycle with out_ready held high.
- Simultaneous events:
  - out_ready=1 in the same cycle s2 reloads is a lossless pass-through.
  - A full pipeline with out_ready=0 accepts nothing.
  - Two stalled entries hold, no overwrite.
- busy = s1_valid | s2_valid.
- Ordering: results leave in grant order. No per-requester reordering.

Decomposition:
- Shared package nn_sched_pkg holds:
  - widths (A_W, B_W, P_W defaults)
  - a stage record typedef {valid, id, a, b}
  - a result typedef {valid, id, p}
  - a function clog2 used for ID_W.
- One natural sub-module: nn_rr_arbiter.
  - Parameterised by NUM_REQ.
  - Inputs req_valid, en (=s1_adv), ap_clk, ap_rst.
  - Outputs grant one-hot, grant_idx, grant_any. It owns rr_ptr.
- The multiplier stays inline in stage 2.

Test Plan:
- Reset flush:
  - Load both stages, assert ap_rst for 1 cycle.
  - Expect out_valid=0 and busy=0 next cycle, and no stale result afterward.
- Single requester:
  - req_valid=4'b0100, a=15, b=31.
  - Expect req_ready=4'b0100 the same cycle; two cycles later out_valid=1, out_id=2, out_data=465.
- Full contention, out_ready=1:
  - req_valid=4'b1111 held, rr_ptr=0.
  - Expect grants 0,1,2,3,0 on consecutive cycles.
  - Results with ids 0,1,2,3,0 on consecutive cycles starting 2 cycles after the first grant.
- Wrap and skip:
  - rr_ptr=3, req_valid=4'b0011.
  - Expect grant 0, then grant 1, then grant 0 (index 3 skipped, wrap correct).
- Backpressure:
  - Issue 3 requests, hold out_ready=0.
  - Expect two accepts, then req_ready all-zero.
  - out_data stable for 5 cycles.
  - Release out_ready: results drain in grant order, then the third request is accepted.
- Truncation:
  - P_W=8, a=15, b=31.
  - Expect out_data=8'hD1 (465 mod 256).
